// File: rtl/vpu_lifecycle_tracker.sv
// vpu_lifecycle_tracker
//   Trace front end for the shuttle-tile vector unit. Watches dispatch, issue
//   queue enq/deq and VAT-release handshakes, tags every vector instruction
//   with a monotonically increasing ID held in a VAT-indexed table, and
//   serialises one cycle's events at a time into timestamped records.
//
//   clock, reset     single clock, synchronous active-high reset
//   dis_fire/vat     dispatch handshake and the VAT tail it allocates
//   enq_fire/vat     per-queue enqueue (queue i at [i*VAT_W +: VAT_W])
//   deq_fire/vat     per-queue dequeue
//   rel_valid/bits   VAT release ports
//   ev_valid/ready   record stream; ev_data = {kind,qidx,orphan,id,ts}
//   drop_cnt         events lost because the snapshot was still draining
//   busy             snapshot or output FIFO holds something

// Per-slot ID lookup with same-cycle dispatch bypass. Release slots are
// built with BYPASS=0 so they see the entry as it stood before this cycle.
module vpu_lifecycle_slot #(
  parameter int VAT_W  = 5,
  parameter int ID_W   = 32,
  parameter int BYPASS = 1
) (
  input  logic [VAT_W-1:0] vat,
  input  logic             ent_valid,
  input  logic [ID_W-1:0]  ent_id,
  input  logic             dis_fire,
  input  logic [VAT_W-1:0] dis_vat,
  input  logic [ID_W-1:0]  new_id,
  output logic [ID_W-1:0]  id,
  output logic             orphan
);
  logic hit;
  assign hit    = (BYPASS != 0) && dis_fire && (vat == dis_vat);
  assign id     = hit ? new_id : (ent_valid ? ent_id : '0);
  assign orphan = !hit && !ent_valid;
endmodule

module vpu_lifecycle_tracker #(
  parameter  int VAT_W      = 5,
  parameter  int NQ         = 5,
  parameter  int NR         = 4,
  parameter  int ID_W       = 32,
  parameter  int TS_W       = 32,
  parameter  int FIFO_DEPTH = 16,
  localparam int REC_W      = 6 + ID_W + TS_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                dis_fire,
  input  logic [VAT_W-1:0]    dis_vat,
  input  logic [NQ-1:0]       enq_fire,
  input  logic [NQ*VAT_W-1:0] enq_vat,
  input  logic [NQ-1:0]       deq_fire,
  input  logic [NQ*VAT_W-1:0] deq_vat,
  input  logic [NR-1:0]       rel_valid,
  input  logic [NR*VAT_W-1:0] rel_bits,
  output logic                ev_valid,
  input  logic                ev_ready,
  output logic [REC_W-1:0]    ev_data,
  output logic [31:0]         drop_cnt,
  output logic                busy
);
  localparam int NS = 1 + 2*NQ + NR;   // event slots, lowest drains first
  localparam int SW = $clog2(NS);
  localparam int NT = 1 << VAT_W;
  localparam int AW = $clog2(FIFO_DEPTH);

  // Slot index -> record kind / queue index
  function automatic logic [1:0] kind_of(input int s);
    if (s == 0)            return 2'd0;
    else if (s <= NQ)      return 2'd1;
    else if (s <= 2*NQ)    return 2'd2;
    else                   return 2'd3;
  endfunction

  function automatic logic [2:0] qidx_of(input int s);
    if (s == 0)            return 3'd0;
    else if (s <= NQ)      return 3'(s - 1);
    else if (s <= 2*NQ)    return 3'(s - 1 - NQ);
    else                   return 3'(s - 1 - 2*NQ);
  endfunction

  // ---------------------------------------------------------------- table
  logic [TS_W-1:0]          ts;
  logic [ID_W-1:0]          next_id;
  logic [NT-1:0]            tbl_vld;
  logic [NT-1:0][ID_W-1:0]  tbl_id;

  always_ff @(posedge clock) begin
    if (reset) begin
      ts      <= '0;
      next_id <= ID_W'(1);
      tbl_vld <= '0;
    end else begin
      ts <= ts + 1'b1;
      for (int r = 0; r < NR; r++)
        if (rel_valid[r]) tbl_vld[rel_bits[r*VAT_W +: VAT_W]] <= 1'b0;
      // Dispatch after the release loop so a same-VAT dispatch wins.
      if (dis_fire) begin
        tbl_vld[dis_vat] <= 1'b1;
        next_id <= (next_id == '1) ? ID_W'(1) : next_id + 1'b1;  // 0 is reserved for orphans
      end
    end
  end

  always_ff @(posedge clock)
    if (dis_fire) tbl_id[dis_vat] <= next_id;

  // -------------------------------------------------------------- capture
  logic [NS-1:0]            cap_fire;
  logic [NS-1:0][VAT_W-1:0] cap_vat;
  logic [NS-1:0][ID_W-1:0]  cap_id;
  logic [NS-1:0]            cap_orph;

  always_comb begin
    cap_fire    = '0;
    cap_vat     = '0;
    cap_fire[0] = dis_fire;
    cap_vat[0]  = dis_vat;
    for (int i = 0; i < NQ; i++) begin
      cap_fire[1+i]    = enq_fire[i];
      cap_vat[1+i]     = enq_vat[i*VAT_W +: VAT_W];
      cap_fire[1+NQ+i] = deq_fire[i];
      cap_vat[1+NQ+i]  = deq_vat[i*VAT_W +: VAT_W];
    end
    for (int r = 0; r < NR; r++) begin
      cap_fire[1+2*NQ+r] = rel_valid[r];
      cap_vat[1+2*NQ+r]  = rel_bits[r*VAT_W +: VAT_W];
    end
  end

  assign cap_id[0]   = next_id;
  assign cap_orph[0] = 1'b0;

  for (genvar g = 1; g < NS; g++) begin : g_slot
    vpu_lifecycle_slot #(
      .VAT_W (VAT_W),
      .ID_W  (ID_W),
      .BYPASS((g <= 2*NQ) ? 1 : 0)
    ) u_slot (
      .vat      (cap_vat[g]),
      .ent_valid(tbl_vld[cap_vat[g]]),
      .ent_id   (tbl_id[cap_vat[g]]),
      .dis_fire (dis_fire),
      .dis_vat  (dis_vat),
      .new_id   (next_id),
      .id       (cap_id[g]),
      .orphan   (cap_orph[g])
    );
  end

  // ------------------------------------------------------------- snapshot
  logic [NS-1:0]           snap_fire;
  logic [NS-1:0][ID_W-1:0] snap_id;
  logic [NS-1:0]           snap_orph;
  logic [TS_W-1:0]         snap_ts;
  logic [SW-1:0]           sel;
  logic                    snap_any, snap_last, accept, drain;

  logic [AW:0]             wr_ptr, rd_ptr, fifo_cnt;
  logic                    full, pop;
  logic [REC_W-1:0]        push_rec;

  always_comb begin
    sel = '0;
    for (int s = NS-1; s >= 0; s--)
      if (snap_fire[s]) sel = SW'(s);
  end

  assign snap_any  = |snap_fire;
  assign fifo_cnt  = wr_ptr - rd_ptr;
  assign full      = (fifo_cnt == (AW+1)'(FIFO_DEPTH));
  assign ev_valid  = (wr_ptr != rd_ptr);
  assign pop       = ev_valid && ev_ready;
  // A pop in the same cycle frees a slot, so a full FIFO can still take a push.
  assign drain     = snap_any && (!full || pop);
  assign snap_last = (snap_fire == (NS'(1) << sel));
  // New events are taken only if the snapshot will be empty after this edge.
  assign accept    = !snap_any || (drain && snap_last);

  always_ff @(posedge clock) begin
    if (reset)       snap_fire <= '0;
    else if (accept) snap_fire <= cap_fire;
    else if (drain)  snap_fire[sel] <= 1'b0;
  end

  always_ff @(posedge clock)
    if (!reset && accept) begin
      snap_id   <= cap_id;
      snap_orph <= cap_orph;
      snap_ts   <= ts;
    end

  // ------------------------------------------------------------ drop count
  logic [31:0] cap_cnt;
  logic [32:0] drop_sum;
  assign cap_cnt  = 32'($countones(cap_fire));
  assign drop_sum = {1'b0, drop_cnt} + {1'b0, cap_cnt};

  always_ff @(posedge clock) begin
    if (reset)                     drop_cnt <= '0;
    else if (!accept && |cap_fire) drop_cnt <= drop_sum[32] ? '1 : drop_sum[31:0];
  end

  // ------------------------------------------------------------ out FIFO
  logic [REC_W-1:0] mem [FIFO_DEPTH];

  assign push_rec = {kind_of(int'(sel)), qidx_of(int'(sel)), snap_orph[sel],
                     snap_id[sel], snap_ts};

  always_ff @(posedge clock)
    if (drain) mem[wr_ptr[AW-1:0]] <= push_rec;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (drain) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign ev_data = mem[rd_ptr[AW-1:0]];
  assign busy    = snap_any || ev_valid;

endmodule

// File: tb/tb_vpu_lifecycle_tracker.sv
module tb_vpu_lifecycle_tracker;
  localparam int VAT_W = 5, NQ = 5, NR = 4, ID_W = 32, TS_W = 32;
  localparam int REC_W = 6 + ID_W + TS_W;

  logic clock = 1'b0, reset = 1'b1;
  always #5 clock = ~clock;

  logic                dis_fire;
  logic [VAT_W-1:0]    dis_vat;
  logic [NQ-1:0]       enq_fire, deq_fire;
  logic [NQ*VAT_W-1:0] enq_vat, deq_vat;
  logic [NR-1:0]       rel_valid;
  logic [NR*VAT_W-1:0] rel_bits;
  logic                ev_valid, ev_ready, busy;
  logic [REC_W-1:0]    ev_data;
  logic [31:0]         drop_cnt;

  vpu_lifecycle_tracker dut (
    .clock(clock), .reset(reset),
    .dis_fire(dis_fire), .dis_vat(dis_vat),
    .enq_fire(enq_fire), .enq_vat(enq_vat),
    .deq_fire(deq_fire), .deq_vat(deq_vat),
    .rel_valid(rel_valid), .rel_bits(rel_bits),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_data(ev_data),
    .drop_cnt(drop_cnt), .busy(busy)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [REC_W-1:0] act, input logic [REC_W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [REC_W-1:0] mk(input int k, input int q, input bit o,
                                           input logic [31:0] id, input logic [31:0] t);
    return {k[1:0], q[2:0], o, id, t};
  endfunction

  // ---------------- reference model: table of IDs, counts of pending records
  bit               m_vld [32];
  logic [31:0]      m_id  [32];
  logic [31:0]      m_next, m_ts, m_drop;
  int               m_snap, m_fifo;
  logic [REC_W-1:0] exp_q [$];

  function automatic void model_reset();
    foreach (m_vld[i]) m_vld[i] = 0;
    m_next = 1; m_ts = 0; m_drop = 0; m_snap = 0; m_fifo = 0;
    exp_q.delete();
  endfunction

  function automatic void lookup(input logic [4:0] v, input bit byp,
                                 output logic [31:0] id, output bit orph);
    if (byp && dis_fire && v == dis_vat) begin id = m_next; orph = 0; end
    else if (m_vld[v])                   begin id = m_id[v]; orph = 0; end
    else                                 begin id = 0;       orph = 1; end
  endfunction

  function automatic void model_step();
    logic [REC_W-1:0] recs [$];
    logic [31:0] id;
    bit orph, pop, drain, accept;
    logic [4:0] v;
    longint s;
    if (dis_fire) recs.push_back(mk(0, 0, 0, m_next, m_ts));
    for (int i = 0; i < NQ; i++)
      if (enq_fire[i]) begin
        v = enq_vat[i*VAT_W +: VAT_W]; lookup(v, 1, id, orph);
        recs.push_back(mk(1, i, orph, id, m_ts));
      end
    for (int i = 0; i < NQ; i++)
      if (deq_fire[i]) begin
        v = deq_vat[i*VAT_W +: VAT_W]; lookup(v, 1, id, orph);
        recs.push_back(mk(2, i, orph, id, m_ts));
      end
    for (int r = 0; r < NR; r++)
      if (rel_valid[r]) begin
        v = rel_bits[r*VAT_W +: VAT_W]; lookup(v, 0, id, orph);
        recs.push_back(mk(3, r, orph, id, m_ts));
      end
    pop    = (m_fifo > 0) && ev_ready;
    drain  = (m_snap > 0) && (m_fifo < 16 || pop);
    accept = (m_snap == 0) || (drain && m_snap == 1);
    m_fifo = m_fifo + int'(drain) - int'(pop);
    m_snap = m_snap - int'(drain);
    if (accept) begin
      m_snap = recs.size();
      foreach (recs[i]) exp_q.push_back(recs[i]);
    end else begin
      s = longint'(m_drop) + recs.size();
      m_drop = (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
    end
    for (int r = 0; r < NR; r++)
      if (rel_valid[r]) m_vld[rel_bits[r*VAT_W +: VAT_W]] = 0;
    if (dis_fire) begin
      m_vld[dis_vat] = 1; m_id[dis_vat] = m_next;
      m_next = m_next + 1;
      if (m_next == 0) m_next = 1;
    end
    m_ts = m_ts + 1;
  endfunction

  // ---------------- driver helpers
  task automatic idle();
    dis_fire = 0; dis_vat = 0; enq_fire = 0; enq_vat = 0;
    deq_fire = 0; deq_vat = 0; rel_valid = 0; rel_bits = 0;
  endtask

  task automatic tick();
    if (reset) model_reset(); else model_step();
    @(posedge clock); #1;
    chk("drop_cnt", REC_W'(drop_cnt), REC_W'(m_drop));
    chk("busy", REC_W'(busy), REC_W'(m_snap > 0 || m_fifo > 0));
    chk("ev_valid", REC_W'(ev_valid), REC_W'(m_fifo > 0));
    idle();
  endtask

  task automatic do_reset();
    reset = 1; tick(); tick(); reset = 0;
  endtask

  task automatic drain_all();
    int k = 0;
    ev_ready = 1;
    while ((m_snap > 0 || m_fifo > 0) && k < 200) begin tick(); k++; end
    chk("drain_busy", REC_W'(busy), '0);
    chk("drain_queue_left", REC_W'(exp_q.size()), '0);
  endtask

  task automatic rand_inputs(input int pct);
    dis_fire = $urandom_range(99) < pct; dis_vat = VAT_W'($urandom_range(7));
    for (int i = 0; i < NQ; i++) begin
      enq_fire[i] = $urandom_range(99) < pct; enq_vat[i*VAT_W +: VAT_W] = VAT_W'($urandom_range(7));
      deq_fire[i] = $urandom_range(99) < pct; deq_vat[i*VAT_W +: VAT_W] = VAT_W'($urandom_range(7));
    end
    for (int r = 0; r < NR; r++) begin
      rel_valid[r] = $urandom_range(99) < pct; rel_bits[r*VAT_W +: VAT_W] = VAT_W'($urandom_range(7));
    end
  endtask

  // ---------------- monitor: pops expected records on each handshake
  initial begin
    logic [REC_W-1:0] e;
    forever begin
      @(negedge clock);
      if (!reset && ev_valid && ev_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL record: got %h expected none", ev_data);
        end else begin
          e = exp_q.pop_front();
          chk("record", ev_data, e);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  // ---------------- stimulus
  initial begin
    idle(); ev_ready = 1;
    do_reset();

    // Single dispatch at cycle 10: two-cycle latency, id 1, ts 10
    repeat (10) tick();
    dis_fire = 1; dis_vat = 3; tick();
    chk("lat_t1_valid", REC_W'(ev_valid), '0);
    tick();
    chk("lat_t2_valid", REC_W'(ev_valid), REC_W'(1));
    chk("lat_t2_rec", ev_data, mk(0, 0, 0, 1, 10));
    drain_all();

    // Dispatch + enqueue on the same VAT in one cycle
    do_reset();
    dis_fire = 1; dis_vat = 3; enq_fire[2] = 1; enq_vat[2*VAT_W +: VAT_W] = 3; tick();
    repeat (4) tick();
    // Release then dequeue of the released VAT
    rel_valid[1] = 1; rel_bits[1*VAT_W +: VAT_W] = 3; tick();
    deq_fire[0] = 1; deq_vat[0 +: VAT_W] = 3; tick();
    drain_all();

    // Release and dispatch on the same VAT in one cycle, then enqueue on it
    dis_fire = 1; dis_vat = 4; tick();
    dis_fire = 1; dis_vat = 4; rel_valid[0] = 1; rel_bits[0 +: VAT_W] = 4; tick();
    enq_fire[3] = 1; enq_vat[3*VAT_W +: VAT_W] = 4; tick();
    drain_all();

    // Stalled consumer: 20 single-event cycles
    do_reset();
    ev_ready = 0;
    for (int i = 0; i < 20; i++) begin dis_fire = 1; dis_vat = VAT_W'(i); tick(); end
    chk("stall_drop", REC_W'(drop_cnt), REC_W'(3));
    chk("stall_busy", REC_W'(busy), REC_W'(1));
    drain_all();

    // Every slot fires, then a dispatch lands while the snapshot drains
    do_reset();
    dis_fire = 1; dis_vat = 1; enq_fire = '1; deq_fire = '1; rel_valid = '1;
    for (int i = 0; i < NQ; i++) begin
      enq_vat[i*VAT_W +: VAT_W] = VAT_W'(i); deq_vat[i*VAT_W +: VAT_W] = VAT_W'(i + 1);
    end
    for (int r = 0; r < NR; r++) rel_bits[r*VAT_W +: VAT_W] = VAT_W'(r * 2);
    tick();
    dis_fire = 1; dis_vat = 9; tick();
    chk("burst_drop", REC_W'(drop_cnt), REC_W'(1));
    drain_all();

    // Reset with records pending
    do_reset();
    ev_ready = 0;
    for (int i = 0; i < 5; i++) begin dis_fire = 1; dis_vat = VAT_W'(i); tick(); end
    tick(); tick();
    reset = 1; tick(); reset = 0;
    chk("rst_ev_valid", REC_W'(ev_valid), '0);
    chk("rst_drop", REC_W'(drop_cnt), '0);
    ev_ready = 1;
    dis_fire = 1; dis_vat = 7; tick();
    tick();
    chk("rst_first_id", ev_data, mk(0, 0, 0, 1, 0));
    drain_all();

    // Randomised traffic at several densities
    do_reset();
    for (int ph = 0; ph < 3; ph++) begin
      for (int c = 0; c < 1000; c++) begin
        rand_inputs(ph == 0 ? 3 : (ph == 1 ? 8 : 20));
        ev_ready = $urandom_range(99) < 70;
        tick();
      end
      drain_all();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
